// File: rtl/mem_write_checker.sv
// mem_write_checker: checks core stores against an expected address/data sequence.
// Define MWC_TIMEOUT_EN to fail a run that makes no progress for TIMEOUT_CYC cycles.
module mem_write_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int N_EXP       = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    memwrite,
    input  logic [ADDR_W-1:0]       dataadr,
    input  logic [DATA_W-1:0]       writedata,
    input  logic [N_EXP*ADDR_W-1:0] exp_addr,
    input  logic [N_EXP*DATA_W-1:0] exp_data,
    input  logic                    ign_en,
    input  logic [ADDR_W-1:0]       ign_addr,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic [4:0]              match_cnt,
    output logic [ADDR_W-1:0]       fail_addr,
    output logic [DATA_W-1:0]       fail_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t              state, state_n;
    logic [4:0]          mc_n;
    logic [ADDR_W-1:0]   fa_n;
    logic [DATA_W-1:0]   fd_n;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_data;
    logic                hit, ign, last;

    generate
        if (N_EXP < 1 || N_EXP > 16 || TIMEOUT_CYC < 1) begin : g_cfg_err
            $error("mem_write_checker: bad N_EXP or TIMEOUT_CYC");
        end
    endgenerate

    // Entry currently awaited; match_cnt < N_EXP whenever it matters.
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int k = 0; k < N_EXP; k++) begin
            if (match_cnt == 5'(k)) begin
                cur_addr = exp_addr[k*ADDR_W +: ADDR_W];
                cur_data = exp_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign hit  = memwrite && (dataadr == cur_addr) && (writedata == cur_data);
    assign ign  = ign_en && (dataadr == ign_addr);
    assign last = (match_cnt == 5'(N_EXP - 1));

`ifdef MWC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] timer, timer_n;
    logic          to_n, expired;

    assign expired = (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            timer   <= timer_n;
            timeout <= to_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        mc_n    = match_cnt;
        fa_n    = fail_addr;
        fd_n    = fail_data;
`ifdef MWC_TIMEOUT_EN
        timer_n = timer;
        to_n    = timeout;
`endif
        unique case (state)
            S_RUN: begin
                // A matching store wins over both the filter and the timer.
                if (hit) begin
                    mc_n = match_cnt + 5'd1;
`ifdef MWC_TIMEOUT_EN
                    timer_n = '0;
`endif
                    if (last) state_n = S_PASS;
                end else if (memwrite && !ign) begin
                    state_n = S_FAIL;
                    fa_n    = dataadr;
                    fd_n    = writedata;
                end else begin
`ifdef MWC_TIMEOUT_EN
                    if (expired) begin
                        state_n = S_FAIL;
                        to_n    = 1'b1;
                        fa_n    = '0;
                        fd_n    = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
`endif
                end
            end
            default: begin
                if (start) begin
                    state_n = S_RUN;
                    mc_n    = '0;
                    fa_n    = '0;
                    fd_n    = '0;
`ifdef MWC_TIMEOUT_EN
                    timer_n = '0;
                    to_n    = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            match_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_n;
            match_cnt <= mc_n;
            fail_addr <= fa_n;
            fail_data <= fd_n;
        end
    end

    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

endmodule
